rv32_ctrl_fsm: RTL and testbench
================================

Name: rv32_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It drives the program counter, the register file write port, the ALU operand muxes and the instruction/data memory request lines from the decoded opcode/funct3. It replaces the current free-running PC enable and tied-off register file controls. It sits beside the decoder and owns every strobe in the datapath.

Parameters:
TIMEOUT_CYCLES, 16, max wait cycles for a memory response in FETCH/MEM before trapping; 0 disables the timeout.
CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
i_opcode  input  7  decoded opcode, instr[6:0]
i_funct3  input  3  decoded funct3
i_branch_taken  input  1  ALU compare result, sampled in EXECUTE
i_imem_valid  input  1  instruction word valid this cycle
i_dmem_ready  input  1  data memory access complete this cycle
o_imem_req  output  1  instruction fetch request
o_ir_load  output  1  capture instruction register (pulse)
o_pc_en  output  1  advance PC (pulse)
o_pc_sel  output  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR)
o_alu_src_a  output  1  0 = rs1, 1 = PC (AUIPC)
o_alu_src_b  output  1  0 = rs2, 1 = immediate
o_rf_we  output  1  register file write enable (pulse)
o_wb_sel  output  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = immediate (LUI)
o_dmem_req  output  1  data memory request
o_dmem_we  output  1  data memory write (store)
o_illegal  output  1  sticky illegal-instruction flag
o_timeout  output  1  sticky memory-timeout flag
o_state  output  3  current state, debug

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; counters 0.
- IDLE: exactly one cycle after rst deasserts, then FETCH.
- FETCH: o_imem_req=1. On i_imem_valid: o_ir_load=1 in the same cycle -> DECODE.
- DECODE: classify i_opcode/i_funct3. Illegal -> TRAP with o_illegal set. Otherwise -> EXECUTE. All strobes are 0.
- Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111 (funct3 must be 000), BRANCH 1100011 (funct3 010/011 illegal), LOAD 0000011 (funct3 011/110/111 illegal), STORE 0100011 (funct3 > 010 illegal), OP-IMM 0010011, OP 0110011, FENCE 0001111 (NOP). SYSTEM and all other opcodes are illegal.
- EXECUTE: one cycle. o_alu_src_a/b held valid for the class. i_branch_taken registered. LOAD/STORE -> MEM; all others -> WB.
- MEM: o_dmem_req=1, o_dmem_we=1 for STORE; both held stable until i_dmem_ready.
  - LOAD on ready -> WB.
  - STORE on ready: o_pc_en=1 with o_pc_sel=0 in that cycle -> FETCH.
- WB: one cycle, o_pc_en=1.
  - o_rf_we=1 except for BRANCH and FENCE.
  - o_pc_sel: BRANCH = taken ? 1 : 0; JAL = 1; JALR = 2; else 0.
  - o_wb_sel per class: JAL/JALR = 2, LUI = 3, LOAD = 1, else 0.
  - -> FETCH.
- x0 write suppression belongs to the register file; the controller does not see rd.
- Latency with zero-wait memories: ALU/branch/jump 4 cycles, load 5, store 4. Exactly one o_pc_en pulse per retired instruction.
- Mux selects are held at their EXECUTE value through MEM/WB and are 0 in IDLE/FETCH/DECODE/TRAP.
- Timeout: a wait counter clears on entry to FETCH/MEM and increments each waiting cycle. If it reaches TIMEOUT_CYCLES with no response -> TRAP, o_timeout=1, request dropped. A response arriving in the same cycle the limit is reached wins.
- TRAP: all strobes and requests 0; flags sticky; exit only via reset.
- Reset mid-operation: immediate return to IDLE; any in-flight request is dropped combinationally with the state.

Optional Feature:
RV32_CTRL_PERF_EN: adds outputs o_cycle_cnt and o_instret_cnt [CNT_WIDTH-1:0].
- o_cycle_cnt increments every cycle outside IDLE/TRAP.
- o_instret_cnt increments on each o_pc_en pulse.
- Both wrap modulo 2^CNT_WIDTH and are reset to 0.
- Without the macro, neither port nor any counter logic exists.

Decomposition:
- rv32_pkg holds: opcode localparams, the state enum (IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP), the pc_sel and wb_sel enums, and the instruction class enum.
- One combinational sub-module, rv32_opclass_decode: opcode/funct3 -> class plus legal flag.

Test Plan:
- ADDI (0010011) with imem valid every cycle -> FETCH..WB in 4 cycles; o_rf_we=1, o_wb_sel=0, o_alu_src_b=1; one o_pc_en with pc_sel=0.
- BEQ with i_branch_taken=1 in EXECUTE -> WB: o_pc_sel=1, o_rf_we=0. Repeat with taken=0 -> o_pc_sel=0.
- LW with i_dmem_ready delayed 3 cycles -> o_dmem_req held 4 cycles, o_dmem_we=0; then WB with o_wb_sel=1, o_rf_we=1; total 8 cycles.
- SW with ready immediate -> o_dmem_we=1; o_pc_en in the MEM cycle; no o_rf_we pulse.
- opcode 1110011 -> TRAP after DECODE, o_illegal=1; no further o_imem_req until rst pulse; IDLE then FETCH after release.
- i_imem_valid held 0 with TIMEOUT_CYCLES=16 -> TRAP after 16 wait cycles, o_timeout=1. Assert rst mid-MEM -> outputs 0 asynchronously.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: opcodes, FSM states, mux-select and instruction-class enums
// shared by the RV32I control sequencer and its opcode classifier.
package rv32_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_MEM     = 3'd4,
      ST_WB      = 3'd5,
      ST_TRAP    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'd0,
      PC_REL   = 2'd1,
      PC_RS1   = 2'd2
   } pc_sel_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2,
      WB_IMM  = 2'd3
   } wb_sel_e;

   typedef enum logic [3:0] {
      CL_NONE   = 4'd0,
      CL_LUI    = 4'd1,
      CL_AUIPC  = 4'd2,
      CL_JAL    = 4'd3,
      CL_JALR   = 4'd4,
      CL_BRANCH = 4'd5,
      CL_LOAD   = 4'd6,
      CL_STORE  = 4'd7,
      CL_OPIMM  = 4'd8,
      CL_OP     = 4'd9,
      CL_FENCE  = 4'd10
   } iclass_e;

   typedef struct packed {
      logic    src_a;
      logic    src_b;
      pc_sel_e pc_sel;
      wb_sel_e wb_sel;
      logic    rf_we;
   } sel_t;

   // Datapath selects implied by an instruction class; taken only
   // matters for branches.
   function automatic sel_t class_sel(input iclass_e cls,
                                      input logic    taken);
      sel_t s;
      s.src_a  = (cls == CL_AUIPC);
      s.src_b  = cls inside {CL_LUI, CL_AUIPC, CL_JALR,
                             CL_LOAD, CL_STORE, CL_OPIMM};
      s.rf_we  = !(cls inside {CL_BRANCH, CL_FENCE,
                               CL_STORE, CL_NONE});
      s.pc_sel = PC_PLUS4;
      s.wb_sel = WB_ALU;
      unique case (cls)
         CL_BRANCH: s.pc_sel = taken ? PC_REL : PC_PLUS4;
         CL_JAL: begin
            s.pc_sel = PC_REL;
            s.wb_sel = WB_PC4;
         end
         CL_JALR: begin
            s.pc_sel = PC_RS1;
            s.wb_sel = WB_PC4;
         end
         CL_LUI:  s.wb_sel = WB_IMM;
         CL_LOAD: s.wb_sel = WB_LOAD;
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/rv32_opclass_decode.sv
// rv32_opclass_decode: combinational opcode/funct3 -> instruction class
// and legal flag. In: i_opcode, i_funct3. Out: o_class, o_legal.
module rv32_opclass_decode
   import rv32_pkg::*;
(
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   output iclass_e    o_class,
   output logic       o_legal
);

   always_comb begin
      o_class = CL_NONE;
      o_legal = 1'b0;
      unique case (1'b1)
         (i_opcode == OPC_LUI): begin
            o_class = CL_LUI;
            o_legal = 1'b1;
         end
         (i_opcode == OPC_AUIPC): begin
            o_class = CL_AUIPC;
            o_legal = 1'b1;
         end
         (i_opcode == OPC_JAL): begin
            o_class = CL_JAL;
            o_legal = 1'b1;
         end
         (i_opcode == OPC_JALR): begin
            o_class = CL_JALR;
            o_legal = (i_funct3 == 3'b000);
         end
         (i_opcode == OPC_BRANCH): begin
            o_class = CL_BRANCH;
            o_legal = (i_funct3 != 3'b010) &&
                      (i_funct3 != 3'b011);
         end
         (i_opcode == OPC_LOAD): begin
            o_class = CL_LOAD;
            o_legal = (i_funct3 != 3'b011) &&
                      (i_funct3 <  3'b110);
         end
         (i_opcode == OPC_STORE): begin
            o_class = CL_STORE;
            o_legal = (i_funct3 <= 3'b010);
         end
         (i_opcode == OPC_OPIMM): begin
            o_class = CL_OPIMM;
            o_legal = 1'b1;
         end
         (i_opcode == OPC_OP): begin
            o_class = CL_OP;
            o_legal = 1'b1;
         end
         (i_opcode == OPC_FENCE): begin
            o_class = CL_FENCE;
            o_legal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/rv32_ctrl_fsm.sv
// rv32_ctrl_fsm: multi-cycle RV32I control sequencer. Inputs: clk, rst
// (async active-low), i_opcode/i_funct3, i_branch_taken, i_imem_valid,
// i_dmem_ready. Outputs: fetch/IR/PC strobes and selects, ALU operand
// selects, RF write/wb select, dmem request/write, sticky o_illegal and
// o_timeout, o_state. Define RV32_CTRL_PERF_EN to add o_cycle_cnt and
// o_instret_cnt performance counters.
module rv32_ctrl_fsm
   import rv32_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
`ifdef RV32_CTRL_PERF_EN
   ,
   parameter int unsigned CNT_WIDTH = 32
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] i_opcode,
   input  logic [2:0] i_funct3,
   input  logic       i_branch_taken,
   input  logic       i_imem_valid,
   input  logic       i_dmem_ready,
   output logic       o_imem_req,
   output logic       o_ir_load,
   output logic       o_pc_en,
   output logic [1:0] o_pc_sel,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_rf_we,
   output logic [1:0] o_wb_sel,
   output logic       o_dmem_req,
   output logic       o_dmem_we,
   output logic       o_illegal,
   output logic       o_timeout,
   output logic [2:0] o_state
`ifdef RV32_CTRL_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] o_cycle_cnt,
   output logic [CNT_WIDTH-1:0] o_instret_cnt
`endif
);

   localparam int unsigned WW =
      (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WW-1:0] WAIT_LAST =
      WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   state_e        state_q;
   state_e        state_d;
   iclass_e       cls_q;
   iclass_e       dec_cls;
   logic          dec_legal;
   logic          taken_q;
   logic [WW-1:0] wait_cnt;
   logic          wait_hit;
   logic          ill_q;
   logic          to_q;
   logic          set_ill;
   logic          set_to;
   logic          sel_act;
   logic          is_store;
   sel_t          sel;

   rv32_opclass_decode u_dec (
      .i_opcode (i_opcode),
      .i_funct3 (i_funct3),
      .o_class  (dec_cls),
      .o_legal  (dec_legal)
   );

   // wait_cnt counts cycles already spent waiting; the cycle where it
   // equals TIMEOUT_CYCLES-1 is the last one a response is accepted.
   assign wait_hit = TO_EN && (wait_cnt == WAIT_LAST);
   assign is_store = (cls_q == CL_STORE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cls_q    <= CL_NONE;
         taken_q  <= 1'b0;
         wait_cnt <= '0;
         ill_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE)
            cls_q <= dec_cls;
         if (state_q == ST_EXECUTE)
            taken_q <= i_branch_taken;
         if (state_d != state_q)
            wait_cnt <= '0;
         else if (state_q inside {ST_FETCH, ST_MEM})
            wait_cnt <= wait_cnt + 1'b1;
         if (set_ill)
            ill_q <= 1'b1;
         if (set_to)
            to_q <= 1'b1;
      end
   end

   // Selects are live from EXECUTE onwards; in EXECUTE the branch
   // outcome comes straight from the ALU, afterwards from taken_q.
   always_comb begin
      sel = class_sel(cls_q, (state_q == ST_EXECUTE) ?
                             i_branch_taken : taken_q);
      sel_act = state_q inside {ST_EXECUTE, ST_MEM, ST_WB};
      o_alu_src_a = sel_act & sel.src_a;
      o_alu_src_b = sel_act & sel.src_b;
      o_pc_sel    = sel_act ? sel.pc_sel : PC_PLUS4;
      o_wb_sel    = sel_act ? sel.wb_sel : WB_ALU;
   end

   always_comb begin
      state_d    = state_q;
      o_imem_req = 1'b0;
      o_ir_load  = 1'b0;
      o_pc_en    = 1'b0;
      o_rf_we    = 1'b0;
      o_dmem_req = 1'b0;
      o_dmem_we  = 1'b0;
      set_ill    = 1'b0;
      set_to     = 1'b0;
      unique case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_valid) begin
               o_ir_load = 1'b1;
               state_d   = ST_DECODE;
            end else if (wait_hit) begin
               set_to  = 1'b1;
               state_d = ST_TRAP;
            end
         end
         ST_DECODE: begin
            if (dec_legal) begin
               state_d = ST_EXECUTE;
            end else begin
               set_ill = 1'b1;
               state_d = ST_TRAP;
            end
         end
         ST_EXECUTE: begin
            if (cls_q inside {CL_LOAD, CL_STORE})
               state_d = ST_MEM;
            else
               state_d = ST_WB;
         end
         ST_MEM: begin
            o_dmem_req = 1'b1;
            o_dmem_we  = is_store;
            if (i_dmem_ready) begin
               if (is_store) begin
                  o_pc_en = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wait_hit) begin
               set_to  = 1'b1;
               state_d = ST_TRAP;
            end
         end
         ST_WB: begin
            o_pc_en = 1'b1;
            o_rf_we = sel.rf_we;
            state_d = ST_FETCH;
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   assign o_illegal = ill_q;
   assign o_timeout = to_q;
   assign o_state   = state_q;

`ifdef RV32_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_cycle_cnt   <= '0;
         o_instret_cnt <= '0;
      end else begin
         if (!(state_q inside {ST_IDLE, ST_TRAP}))
            o_cycle_cnt <= o_cycle_cnt + 1'b1;
         if (o_pc_en)
            o_instret_cnt <= o_instret_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_rv32_ctrl_fsm.sv
// tb_rv32_ctrl_fsm: randomized instruction stream against a per-instruction
// expected-trace model, plus directed latency/trap/reset checks.
module tb_rv32_ctrl_fsm;

   localparam int TO = 16;

   localparam int S_IDLE = 0;
   localparam int S_FETCH = 1;
   localparam int S_DECODE = 2;
   localparam int S_EXEC = 3;
   localparam int S_MEM = 4;
   localparam int S_WB = 5;
   localparam int S_TRAP = 6;

   localparam logic [6:0] LUI = 7'b0110111;
   localparam logic [6:0] AUIPC = 7'b0010111;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD = 7'b0000011;
   localparam logic [6:0] STORE = 7'b0100011;
   localparam logic [6:0] OPIMM = 7'b0010011;
   localparam logic [6:0] OPR = 7'b0110011;
   localparam logic [6:0] FENCE = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       taken = 1'b0;
   logic       imem_valid = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       o_imem_req, o_ir_load, o_pc_en;
   logic [1:0] o_pc_sel, o_wb_sel;
   logic       o_alu_src_a, o_alu_src_b, o_rf_we;
   logic       o_dmem_req, o_dmem_we, o_illegal, o_timeout;
   logic [2:0] o_state;
`ifdef RV32_CTRL_PERF_EN
   logic [31:0] o_cycle_cnt, o_instret_cnt;
`endif

   always #5 clk = ~clk;

   rv32_ctrl_fsm #(.TIMEOUT_CYCLES(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_opcode       (opcode),
      .i_funct3       (funct3),
      .i_branch_taken (taken),
      .i_imem_valid   (imem_valid),
      .i_dmem_ready   (dmem_ready),
      .o_imem_req     (o_imem_req),
      .o_ir_load      (o_ir_load),
      .o_pc_en        (o_pc_en),
      .o_pc_sel       (o_pc_sel),
      .o_alu_src_a    (o_alu_src_a),
      .o_alu_src_b    (o_alu_src_b),
      .o_rf_we        (o_rf_we),
      .o_wb_sel       (o_wb_sel),
      .o_dmem_req     (o_dmem_req),
      .o_dmem_we      (o_dmem_we),
      .o_illegal      (o_illegal),
      .o_timeout      (o_timeout),
`ifdef RV32_CTRL_PERF_EN
      .o_cycle_cnt    (o_cycle_cnt),
      .o_instret_cnt  (o_instret_cnt),
`endif
      .o_state        (o_state)
   );

   int checks = 0;
   int failures = 0;
   int pc_en_cnt = 0;
   int retired_m = 0;
   int cyc_g = 0;
   int lat_g = 0;
   bit pce_now = 1'b0;
   bit ill_m = 1'b0;
   bit to_m = 1'b0;
   bit chk_en = 1'b0;
   logic [16:0] exp_v = '0;
   string exp_tag = "none";
   logic [16:0] act_v;

   assign act_v = {o_state, o_imem_req, o_ir_load, o_pc_en, o_pc_sel,
                   o_alu_src_a, o_alu_src_b, o_rf_we, o_wb_sel,
                   o_dmem_req, o_dmem_we, o_illegal, o_timeout};

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)",
                     exp_tag, act_v, exp_v, $time);
         end
      end
   end

   always @(negedge clk)
      if (rst && o_pc_en === 1'b1)
         pc_en_cnt++;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic logic [16:0] mk(
      input int st, input bit ireq, input bit irl, input bit pce,
      input logic [1:0] ps, input bit a, input bit b, input bit we,
      input logic [1:0] ws, input bit dr, input bit dw);
      logic [2:0] s3;
      s3 = 3'(st);
      return {s3, ireq, irl, pce, ps, a, b, we, ws, dr, dw, ill_m, to_m};
   endfunction

   function automatic logic [16:0] quiet(input int st);
      return mk(st, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0);
   endfunction

   function automatic bit legal(input logic [6:0] op,
                                input logic [2:0] f3);
      case (op)
         LUI, AUIPC, JAL, OPIMM, OPR, FENCE: return 1'b1;
         JALR:   return f3 == 3'd0;
         BRANCH: return !(f3 == 3'd2 || f3 == 3'd3);
         LOAD:   return !(f3 == 3'd3 || f3 >= 3'd6);
         STORE:  return f3 <= 3'd2;
         default: return 1'b0;
      endcase
   endfunction

   // {pc_sel, alu_src_a, alu_src_b, wb_sel}
   function automatic logic [5:0] sels(input logic [6:0] op, input bit t);
      logic [1:0] ps;
      logic [1:0] ws;
      bit a;
      bit b;
      ps = 2'd0;
      ws = 2'd0;
      a = (op == AUIPC);
      b = (op == OPIMM) || (op == LOAD) || (op == STORE) ||
          (op == AUIPC) || (op == JALR) || (op == LUI);
      if (op == BRANCH) ps = t ? 2'd1 : 2'd0;
      else if (op == JAL) ps = 2'd1;
      else if (op == JALR) ps = 2'd2;
      if (op == JAL || op == JALR) ws = 2'd2;
      else if (op == LUI) ws = 2'd3;
      else if (op == LOAD) ws = 2'd1;
      return {ps, a, b, ws};
   endfunction

   task automatic step(input bit v, input bit r, input bit t,
                       input logic [16:0] e, input string tag);
      @(posedge clk);
      #1;
      imem_valid = v;
      dmem_ready = r;
      taken = t;
      exp_v = e;
      exp_tag = tag;
      chk_en = 1'b1;
      #1;
      pce_now = (o_pc_en === 1'b1);
      cyc_g++;
      if (pce_now && lat_g == 0)
         lat_g = cyc_g;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      imem_valid = rb();
      dmem_ready = rb();
      exp_v = quiet(S_IDLE);
      exp_tag = "idle_after_reset";
      chk_en = 1'b1;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      #1;
      chk_en = 1'b0;
      rst = 1'b0;
      #1;
      check(tag, 32'(act_v), 32'd0);
      ill_m = 1'b0;
      to_m = 1'b0;
      release_reset();
   endtask

   task automatic trap_steps(input string tag);
      repeat (3) step(rb(), rb(), rb(), quiet(S_TRAP), tag);
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                            input bit t, input int fd, input int md,
                            output int lat);
      logic [5:0] s;
      bit is_mem;
      bit is_st;
      bit we;
      cyc_g = 0;
      lat_g = 0;
      lat = 0;
      opcode = op;
      funct3 = f3;
      for (int k = 0; k <= fd && k < TO; k++)
         step(k == fd, rb(), rb(),
              mk(S_FETCH, 1, k == fd, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0),
              "fetch");
      if (fd >= TO) begin
         to_m = 1'b1;
         trap_steps("fetch_timeout_trap");
         check("timeout_flag", 32'(o_timeout), 32'd1);
         apply_reset("reset_after_timeout");
         return;
      end
      step(rb(), rb(), rb(), quiet(S_DECODE), "decode");
      if (!legal(op, f3)) begin
         ill_m = 1'b1;
         trap_steps("illegal_trap");
         check("illegal_flag", 32'(o_illegal), 32'd1);
         apply_reset("reset_after_illegal");
         return;
      end
      s = sels(op, t);
      is_mem = (op == LOAD) || (op == STORE);
      is_st = (op == STORE);
      we = !(op == BRANCH || op == FENCE);
      step(rb(), rb(), t,
           mk(S_EXEC, 0, 0, 0, s[5:4], s[3], s[2], 0, s[1:0], 0, 0),
           "execute");
      if (is_mem) begin
         for (int k = 0; k <= md && k < TO; k++)
            step(rb(), k == md, rb(),
                 mk(S_MEM, 0, 0, is_st && k == md, s[5:4], s[3], s[2],
                    0, s[1:0], 1, is_st),
                 "mem");
         if (md >= TO) begin
            to_m = 1'b1;
            trap_steps("mem_timeout_trap");
            check("mem_timeout_flag", 32'(o_timeout), 32'd1);
            apply_reset("reset_after_mem_timeout");
            return;
         end
         if (is_st) begin
            retired_m++;
            lat = lat_g;
            return;
         end
      end
      step(rb(), rb(), !t,
           mk(S_WB, 0, 0, 1, s[5:4], s[3], s[2], we, s[1:0], 0, 0),
           "writeback");
      retired_m++;
      lat = lat_g;
   endtask

   logic [6:0] optab [11] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD,
                              STORE, OPIMM, OPR, FENCE, SYSTEM};

   initial begin
      int lat;
      int pick;
      int fd;
      int md;
      logic [6:0] op;
      logic [5:0] s;

      #2;
      check("reset_state", 32'(act_v), 32'd0);
      release_reset();

      run_instr(OPIMM, 3'd0, 1'b0, 0, 0, lat);
      check("lat_addi", lat, 4);
      run_instr(BRANCH, 3'd0, 1'b1, 0, 0, lat);
      check("lat_beq_taken", lat, 4);
      run_instr(BRANCH, 3'd0, 1'b0, 0, 0, lat);
      check("lat_beq_not_taken", lat, 4);
      run_instr(LOAD, 3'd2, 1'b0, 0, 3, lat);
      check("lat_lw_wait3", lat, 8);
      run_instr(STORE, 3'd2, 1'b0, 0, 0, lat);
      check("lat_sw", lat, 4);
      run_instr(LOAD, 3'd0, 1'b0, 0, 0, lat);
      check("lat_lb", lat, 5);
      run_instr(JALR, 3'd0, 1'b0, 0, 0, lat);
      check("lat_jalr", lat, 4);
      run_instr(OPIMM, 3'd0, 1'b0, TO - 1, 0, lat);
      check("lat_fetch_last_wait", lat, TO + 3);
      run_instr(LOAD, 3'd1, 1'b0, 0, TO - 1, lat);
      check("lat_mem_last_wait", lat, TO + 4);
      run_instr(SYSTEM, 3'd0, 1'b0, 0, 0, lat);
      run_instr(OPIMM, 3'd0, 1'b0, TO, 0, lat);
      run_instr(STORE, 3'd0, 1'b0, 0, TO, lat);

      opcode = LOAD;
      funct3 = 3'd2;
      s = sels(LOAD, 1'b0);
      step(1, 0, 0,
           mk(S_FETCH, 1, 1, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0), "mm_fetch");
      step(0, 0, 0, quiet(S_DECODE), "mm_decode");
      step(0, 0, 0,
           mk(S_EXEC, 0, 0, 0, s[5:4], s[3], s[2], 0, s[1:0], 0, 0),
           "mm_execute");
      repeat (2)
         step(0, 0, 0,
              mk(S_MEM, 0, 0, 0, s[5:4], s[3], s[2], 0, s[1:0], 1, 0),
              "mm_mem");
      apply_reset("reset_mid_mem");

      for (int n = 0; n < 200; n++) begin
         pick = $urandom_range(0, 15);
         if (pick < 11) op = optab[pick];
         else op = 7'($urandom);
         fd = ($urandom_range(0, 19) == 0) ?
              $urandom_range(4, TO) : $urandom_range(0, 3);
         md = ($urandom_range(0, 19) == 0) ?
              $urandom_range(4, TO) : $urandom_range(0, 3);
         run_instr(op, 3'($urandom), rb(), fd, md, lat);
      end

      @(negedge clk);
      #1;
      check("retire_count", pc_en_cnt, retired_m);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
